// File: rtl/hex_scroll_pkg.sv
// Shared constants and types for the hex scroll writer: character code width, blank code, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hex_scroll_pkg;

  // Width of one display character code.
  localparam int CHAR_W = 5;

  // Code that the hex decoders render as an unlit digit.
  localparam logic [CHAR_W-1:0] BLANK_CHAR = 5'b11111;

  typedef logic [CHAR_W-1:0] char_t;

  // Writer FSM: collect characters (IDLE/LOAD), then rotate them across the display (SCROLL).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2
  } state_t;

endpackage

// File: rtl/hex_scroll_writer_tick_gen.sv
// Scroll-rate prescaler: one-cycle tick every TICK_DIV cycles while run is high.
// Latency: first tick TICK_DIV cycles after run rises (counter starts from zero).
// Backpressure: none; counter is held at zero whenever run is low.
module scroll_tick_gen #(
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TERM = TW'(TICK_DIV - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Terminal count doubles as the tick; it only counts while the scroller runs.
  assign tick = run && (cnt_q == TERM);

  // Next count: wrap at the terminal value, hold at zero while stopped.
  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_scroll_writer.sv
// Loadable message source for six hex-digit decoders; rotates a stored message at the tick rate. Optional SCROLL_DIR_EN adds scroll_left.
// Latency: window is registered, first window one cycle after entering SCROLL, head changes show one cycle later.
// Backpressure: wr_ready is high in IDLE/LOAD and low for the whole SCROLL phase; clear always wins over a write.
module hex_scroll_writer
  import hex_scroll_pkg::*;
#(
  parameter int unsigned MSG_LEN    = 18,
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned TICK_DIV   = 12500000
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [CHAR_W-1:0]            wr_char,
  input  logic                         wr_last,
`ifdef SCROLL_DIR_EN
  input  logic                         scroll_left,
`endif
  output logic                         display_en,
  output logic [NUM_DIGITS*CHAR_W-1:0] window
);

  // count/len/head all fit 0..MSG_LEN; the index sum head+j needs one extra bit.
  localparam int CNT_W = $clog2(MSG_LEN + 1);
  localparam int IDX_W = CNT_W + 1;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [CNT_W-1:0]               len_q, len_d;
  logic [CNT_W-1:0]               head_q, head_d;
  logic [NUM_DIGITS*CHAR_W-1:0]   window_q, window_d;

  char_t                          msg_q [MSG_LEN];
  logic                           msg_we;
  logic [CNT_W-1:0]               msg_waddr;
  char_t                          msg_wdat;

  logic [CNT_W-1:0]               count_inc;
  logic                           accept;
  logic                           tick;
  logic                           tick_run;
  logic                           dir_fwd;
  logic [IDX_W-1:0]               win_idx;

  // Both handshake outputs follow the state register directly, so reset and clear drive them cleanly.
  assign wr_ready   = (state_q != SCROLL);
  assign display_en = (state_q == SCROLL);
  assign window     = window_q;

  assign accept    = wr_valid & wr_ready & ~clear;
  assign count_inc = count_q + CNT_W'(1);

  // Prescaler restarts from zero on every SCROLL entry and is stopped by clear.
  assign tick_run = (state_q == SCROLL) & ~clear;

`ifdef SCROLL_DIR_EN
  assign dir_fwd = scroll_left;
`else
  assign dir_fwd = 1'b1;
`endif

  scroll_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .run      (tick_run),
    .tick     (tick)
  );

  // FSM, character counter, message length and scroll head.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    len_d     = len_q;
    head_d    = head_q;
    msg_we    = 1'b0;
    msg_waddr = count_q;
    msg_wdat  = wr_char;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      len_d   = '0;
      head_d  = '0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            msg_we  = 1'b1;
            count_d = count_inc;
            if (wr_last || (count_inc == CNT_W'(MSG_LEN))) begin
              state_d = SCROLL;
              len_d   = count_inc;
              head_d  = '0;
            end else begin
              state_d = LOAD;
            end
          end
        end
        SCROLL: begin
          // Direction is looked at only on the tick itself.
          if (tick) begin
            if (dir_fwd) begin
              head_d = (head_q == len_q - CNT_W'(1)) ? '0 : head_q + CNT_W'(1);
            end else begin
              head_d = (head_q == '0) ? len_q - CNT_W'(1) : head_q - CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Next window: digit j (hex5 first) shows msg[(head+j) mod len], blank past the message length.
  always_comb begin
    window_d = {NUM_DIGITS{BLANK_CHAR}};
    win_idx  = '0;
    if ((state_q == SCROLL) && !clear) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        // head < len and j < len, so a single subtraction completes the wrap.
        win_idx = {1'b0, head_q} + IDX_W'(j);
        if (win_idx >= {1'b0, len_q}) begin
          win_idx = win_idx - {1'b0, len_q};
        end
        if (IDX_W'(j) < {1'b0, len_q}) begin
          window_d[(NUM_DIGITS-1-j)*CHAR_W +: CHAR_W] = msg_q[win_idx[CNT_W-1:0]];
        end
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      len_q    <= '0;
      head_q   <= '0;
      window_q <= {NUM_DIGITS{BLANK_CHAR}};
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      len_q    <= len_d;
      head_q   <= head_d;
      window_q <= window_d;
    end
  end

  // Message buffer; contents are meaningless until rewritten, so it carries no reset.
  always_ff @(posedge CLOCK_50) begin
    if (msg_we) begin
      msg_q[msg_waddr] <= msg_wdat;
    end
  end

endmodule
